// File: rtl/mux4_pkg.sv
// Shared definitions for the four-requester round-robin mux scheduler.
//   NREQ          : number of requesters (one per mux data input)
//   sel_t         : mux select / requester index
//   sched_state_t : scheduler state (IDLE, OWN)
//   rr_pick       : rotate-priority search returning {found, index}
package mux4_pkg;

    localparam int unsigned NREQ = 4;

    typedef logic [1:0] sel_t;

    typedef enum logic [0:0] {IDLE, OWN} sched_state_t;

    typedef struct packed {
        logic found;
        sel_t idx;
    } pick_t;

    // First requester with req set, searching start, start+1, ... modulo NREQ.
    // Walking the offsets downwards lets the smallest offset win the final assignment.
    function automatic pick_t rr_pick(input logic [NREQ-1:0] req, input sel_t start);
        pick_t res;
        sel_t  idx;
        res = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = start + sel_t'(i);
            if (req[idx]) begin
                res.found = 1'b1;
                res.idx   = idx;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mux4_rr_pick.sv
// Combinational rotate-priority encoder.
//   req    : request bits
//   start  : index with the highest priority
//   valid  : at least one request bit is set
//   index  : chosen requester index
//   onehot : one-hot form of index, zero when nothing is requested
module mux4_rr_pick
    import mux4_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] start,
    output logic       valid,
    output logic [1:0] index,
    output logic [3:0] onehot
);

    pick_t pick;

    always_comb begin
        pick   = rr_pick(req, start);
        valid  = pick.found;
        index  = pick.idx;
        onehot = pick.found ? (NREQ'(1) << pick.idx) : '0;
    end

endmodule

// File: rtl/mux4_rr_sched.sv
// Round-robin scheduler owning the select pins of a shared 4:1 single-bit mux.
//   clk   : clock, all state updates on the rising edge
//   rst   : synchronous active-high reset
//   req   : request bits, req[k] asks for mux input k
//   grant : one-hot current owner, zero when idle
//   S1/S0 : mux select, owner index (held at last owner while idle)
//   busy  : a grant is active
// Every output comes straight from a register; nothing is combinational from req.
module mux4_rr_sched
    import mux4_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic       S1,
    output logic       S0,
    output logic       busy
);

    localparam int unsigned      CW       = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0]    HOLD_MAX = CW'(HOLD_CYCLES);

    sched_state_t   state_q, state_d;
    sel_t           ptr_q, ptr_d;
    sel_t           sel_q, sel_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [3:0]     grant_q, grant_d;

    logic           idle_valid;
    sel_t           idle_index;
    logic [3:0]     idle_onehot;

    logic [3:0]     rel_req;
    sel_t           rel_start;
    logic           rel_valid;
    sel_t           rel_index;
    logic [3:0]     rel_onehot;

    // Owner is masked out so a release always prefers one of the other three.
    assign rel_req   = req & ~grant_q;
    assign rel_start = sel_q + 2'd1;

    mux4_rr_pick u_pick_idle (
        .req    (req),
        .start  (ptr_q),
        .valid  (idle_valid),
        .index  (idle_index),
        .onehot (idle_onehot)
    );

    mux4_rr_pick u_pick_rel (
        .req    (rel_req),
        .start  (rel_start),
        .valid  (rel_valid),
        .index  (rel_index),
        .onehot (rel_onehot)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        unique case (state_q)
            IDLE: begin
                if (idle_valid) begin
                    state_d = OWN;
                    sel_d   = idle_index;
                    grant_d = idle_onehot;
                    cnt_d   = CW'(1);
                end
            end
            OWN: begin
                if (!req[sel_q] || (cnt_q == HOLD_MAX)) begin
                    ptr_d = sel_q + 2'd1;
                    if (rel_valid) begin
                        // Hand over in the same edge, no idle bubble.
                        sel_d   = rel_index;
                        grant_d = rel_onehot;
                        cnt_d   = CW'(1);
                    end else if (req[sel_q]) begin
                        // Hold expired but nobody else wants the mux.
                        cnt_d = CW'(1);
                    end else begin
                        // Select keeps the last owner index while idle.
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        grant = grant_q;
        S1    = sel_q[1];
        S0    = sel_q[0];
        busy  = (state_q == OWN);
    end

endmodule

// File: doc/mux4_rr_sched.md
Name: mux4_rr_sched

Overview:
- Round-robin scheduler that shares the 4:1 single-bit multiplexer (inputs i0..i3, selects S1/S0, output y) among four requesters.
- Each requester raises a request bit. The scheduler grants the mux to one requester at a time and drives S1/S0 so that requester's input appears on y.
- Ownership is bounded by a hold limit so that one requester cannot starve the other three.
- Sits directly in front of the multiplexer instance. S1/S0 wire straight to the mux select pins.

Parameters:
- HOLD_CYCLES, 4, maximum consecutive cycles one owner keeps the grant; legal range 1..255.
- CW, $clog2(HOLD_CYCLES+1), hold counter width (derived; not overridden).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request bits; req[k] asks for mux input ik.
- grant  output  4  one-hot current owner; 4'b0000 when idle.
- S1  output  1  mux select MSB = owner index bit 1.
- S0  output  1  mux select LSB = owner index bit 0.
- busy  output  1  high while a grant is active (y is valid for the owner).

Behaviour:
- All outputs are registered; none is combinational from req.
- Reset (rst=1 at a rising edge) returns to the following, and rst overrides every other event in the same cycle:
  - grant=0000, S1=0, S0=0, busy=0.
  - state=IDLE, priority pointer ptr=0, hold counter cnt=0.
- States: IDLE, OWN.
- IDLE:
  - If req==0000 at an edge, remain IDLE; grant, busy and S1/S0 hold their values (S1/S0 keep the last owner index).
  - If req!=0000, go to OWN with owner = first k with req[k]=1, searching ptr, ptr+1, ... mod 4.
  - Set grant=onehot(owner), {S1,S0}=owner, busy=1, cnt=1.
  - Latency: req sampled at edge n gives grant visible after edge n.
- OWN with owner o: release occurs at an edge if req[o]==0, or if cnt==HOLD_CYCLES.
- On release:
  - ptr <= o+1 mod 4.
  - The next owner is searched among the other three requesters, from o+1 onward.
  - If any of them requests, switch directly to that owner in the same edge with no idle bubble; grant, S1/S0 and busy stay 1; cnt=1.
  - If none of them requests but req[o] is still 1 (hold expired), re-grant o with cnt=1.
  - If req==0000, go to IDLE with grant=0000 and busy=0; S1/S0 hold o.
- No release: cnt <= cnt+1; all outputs unchanged.
- HOLD_CYCLES=1: ownership rotates every cycle among all active requesters.
- Invariants:
  - grant is always one-hot or zero.
  - {S1,S0} equals the index of the set grant bit whenever busy=1.
  - A requester holding req continuously waits at most 3*HOLD_CYCLES cycles before being granted.
- Request changes by non-owners while in OWN take effect only at the next release decision.

Decomposition:
- Shared package mux4_pkg holds:
  - localparam NREQ=4.
  - typedef logic [1:0] sel_t.
  - typedef enum {IDLE, OWN} sched_state_t.
  - Function rr_pick(req, start) returning {found, sel_t}.
- One natural sub-module: mux4_rr_pick, a combinational rotate-priority encoder (4-bit req, 2-bit start → valid, 2-bit index, one-hot). It is instantiated once for IDLE selection and once, with the owner masked, for release selection.
- The existing multiplexer is instantiated only by the integration top, not inside this block.

Test Plan:
- Reset then idle: assert rst for 2 cycles with req=1111, release rst, req=0000 → grant=0000, S1=S0=0, busy=0 and unchanged for 10 cycles.
- Single requester, hold expiry: HOLD_CYCLES=4, req=0100 held steady → grant=0100, {S1,S0}=10 from cycle 1 onward, busy=1 continuously; owner re-granted every 4 cycles with no gap; y equals i2.
- Round-robin rotation: req=1111 held, HOLD_CYCLES=2 → owner sequence 0,0,1,1,2,2,3,3,0,... with {S1,S0} following and no idle cycle between owners.
- Early release and pointer: owner 1 drops req after 1 cycle while req=1011 → next owner is 3 (search from 2, skipping non-requesting 2); ptr=2 afterward.
- Last requester drops: only owner 2 active, req goes 0100 → 0000 → next edge grant=0000, busy=0, {S1,S0} holds 10; a later req=0001 grants 0 one cycle after sampling.
- Reset mid-operation: rst=1 during OWN (owner 3, cnt=2) with req=1111 → after that edge grant=0000, busy=0, S1=S0=0; after rst drops, first grant goes to 0 (ptr reset).
